// File: rtl/lenet_pkg.sv
// Shared LeNet datapath constants: layer geometry, address widths,
// pixel lane format and the pool sequencer state encoding.
package lenet_pkg;

  localparam int LANES    = 6;
  localparam int LANE_W   = 16;

  localparam int C1_IN_W  = 32;
  localparam int C1_OUT_W = 28;

  localparam int P1_IN_W  = 28;
  localparam int P1_OUT_W = 14;
  localparam int P1_RA_W  = 10;
  localparam int P1_WA_W  = 8;
  localparam int P1_RD_LAT = 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_RUN   = S_RUN,
    ST_DRAIN = S_DRAIN,
    ST_DONE  = S_DONE
  } p1_state_t;

endpackage

// File: rtl/win_addr_gen.sv
// 2x2 window scan: row/col/phase counters and f2 address.
// Ports: i_clk, i_rst (sync, high), i_en advance; o_raddr, o_p0/o_p3 phase flags, o_last.
module win_addr_gen
  import lenet_pkg::*;
#(
  parameter int IN_W = P1_IN_W,
  parameter int RA_W = P1_RA_W
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  output logic [RA_W-1:0] o_raddr,
  output logic            o_p0,
  output logic            o_p3,
  output logic            o_last
);

  logic [RA_W-1:0] r_col;
  logic [RA_W-1:0] r_row;
  logic [1:0]      r_ph;

  logic            w_col_end;
  logic            w_row_end;
  logic [RA_W-1:0] w_row_eff;
  logic [RA_W-1:0] w_col_eff;

  assign w_col_end = (r_col == RA_W'(IN_W - 2));
  assign w_row_end = (r_row == RA_W'(IN_W - 2));

  // phase bit 1 selects the lower row, bit 0 the right column
  assign w_row_eff = r_row + RA_W'(r_ph[1]);
  assign w_col_eff = r_col + RA_W'(r_ph[0]);
  assign o_raddr   = w_row_eff * RA_W'(IN_W) + w_col_eff;

  assign o_p0   = (r_ph == 2'd0);
  assign o_p3   = (r_ph == 2'd3);
  assign o_last = o_p3 & w_col_end & w_row_end;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col <= '0;
      r_row <= '0;
      r_ph  <= '0;
    end else if (i_en) begin
      r_ph <= r_ph + 2'd1;
      if (r_ph == 2'd3) begin
        if (w_col_end) begin
          r_col <= '0;
          r_row <= w_row_end ? '0 : r_row + RA_W'(2);
        end else begin
          r_col <= r_col + RA_W'(2);
        end
      end
    end
  end

endmodule

// File: rtl/pool1_ctrl.sv
// pool1 sequencer: scans f2 in 2x2 windows, times pool1_clr and f3 writes.
// Ports: clk, rst_n (sync, high), start; busy, done, f2_ren/raddr, pool1_clr, f3_wen/waddr.
module pool1_ctrl
  import lenet_pkg::*;
#(
  parameter int IN_W   = P1_IN_W,
  parameter int OUT_W  = P1_OUT_W,
  parameter int RA_W   = P1_RA_W,
  parameter int WA_W   = P1_WA_W,
  parameter int RD_LAT = P1_RD_LAT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            f2_ren,
  output logic [RA_W-1:0] f2_raddr,
  output logic            pool1_clr,
  output logic            f3_wen,
  output logic [WA_W-1:0] f3_waddr
);

  localparam int DW = $clog2(RD_LAT + 2);

  p1_state_t       r_state;
  logic [DW-1:0]   r_drn;
  logic [RD_LAT-1:0] r_p0_dly;
  logic [RD_LAT:0] r_p3_dly;
  logic [WA_W-1:0] r_waddr;

  logic            w_run;
  logic            w_p0;
  logic            w_p3;
  logic            w_last;
  logic [RA_W-1:0] w_raddr;

  assign w_run = (r_state == ST_RUN);

  win_addr_gen #(
    .IN_W (IN_W),
    .RA_W (RA_W)
  ) u_addr (
    .i_clk   (clk),
    .i_rst   (rst_n),
    .i_en    (w_run),
    .o_raddr (w_raddr),
    .o_p0    (w_p0),
    .o_p3    (w_p3),
    .o_last  (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= ST_IDLE;
      r_drn   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) r_state <= ST_RUN;
        end
        ST_RUN: begin
          r_drn <= '0;
          if (w_last) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // RD_LAT+1 cycles: last data arrives, then the last write issues
          if (r_drn == DW'(RD_LAT)) r_state <= ST_DONE;
          else r_drn <= r_drn + DW'(1);
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // phase-0 marker lands on the data cycle; phase-3 marker one cycle
  // later, once acc holds the full window max
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_p0_dly <= '0;
      r_p3_dly <= '0;
      r_waddr  <= '0;
    end else begin
      r_p0_dly[0] <= w_run & w_p0;
      for (int i = 1; i < RD_LAT; i++) r_p0_dly[i] <= r_p0_dly[i-1];
      r_p3_dly[0] <= w_run & w_p3;
      for (int i = 1; i <= RD_LAT; i++) r_p3_dly[i] <= r_p3_dly[i-1];
      if (r_p3_dly[RD_LAT]) begin
        if (r_waddr == WA_W'(OUT_W * OUT_W - 1)) r_waddr <= '0;
        else r_waddr <= r_waddr + WA_W'(1);
      end
    end
  end

  assign f2_ren    = w_run;
  assign f2_raddr  = w_raddr;
  assign pool1_clr = r_p0_dly[RD_LAT-1];
  assign f3_wen    = r_p3_dly[RD_LAT];
  assign f3_waddr  = r_waddr;
  assign busy      = w_run | (r_state == ST_DRAIN);
  assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_pool1_ctrl.sv
// Directed bench for pool1_ctrl: default map plus a 4x4 / RD_LAT=2 instance.
// Per-cycle timing checks against closed-form schedule, plus pooled data check.
module tb_pool1_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic s_start;

  logic       busy, done, f2_ren, pool1_clr, f3_wen;
  logic [9:0] f2_raddr;
  logic [7:0] f3_waddr;

  logic       s_busy, s_done, s_f2_ren, s_pool1_clr, s_f3_wen;
  logic [3:0] s_f2_raddr;
  logic [1:0] s_f3_waddr;

  int n_vec = 0;
  int n_err = 0;
  int cur_t = 0;

  logic signed [15:0] rdata;
  logic signed [15:0] acc;
  logic signed [15:0] f3mem [196];

  always #5 clk = ~clk;

  pool1_ctrl u_dut (
    .clk       (clk),
    .rst_n     (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .f2_ren    (f2_ren),
    .f2_raddr  (f2_raddr),
    .pool1_clr (pool1_clr),
    .f3_wen    (f3_wen),
    .f3_waddr  (f3_waddr)
  );

  pool1_ctrl #(
    .IN_W   (4),
    .OUT_W  (2),
    .RA_W   (4),
    .WA_W   (2),
    .RD_LAT (2)
  ) u_sml (
    .clk       (clk),
    .rst_n     (rst),
    .start     (s_start),
    .busy      (s_busy),
    .done      (s_done),
    .f2_ren    (s_f2_ren),
    .f2_raddr  (s_f2_raddr),
    .pool1_clr (s_pool1_clr),
    .f3_wen    (s_f3_wen),
    .f3_waddr  (s_f3_waddr)
  );

  function automatic logic signed [15:0] pix(input int a);
    return 16'(a % 97 - 48);
  endfunction

  function automatic logic signed [15:0] smax(
    input logic signed [15:0] a, input logic signed [15:0] b);
    return (a > b) ? a : b;
  endfunction

  // f2 buffer (RD_LAT=1) and one pool_unit lane
  always @(posedge clk) begin
    if (f2_ren) rdata <= pix(int'(f2_raddr));
    acc <= pool1_clr ? rdata : smax(acc, rdata);
    if (f3_wen) f3mem[f3_waddr] <= acc;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got %0d want %0d",
               tag, cur_t, $signed(got), $signed(exp));
    end
  endtask

  task automatic chk_zero(input bit sml);
    if (sml) begin
      chk("s_rst_busy", 32'(s_busy), 0);
      chk("s_rst_done", 32'(s_done), 0);
      chk("s_rst_ren", 32'(s_f2_ren), 0);
      chk("s_rst_raddr", 32'(s_f2_raddr), 0);
      chk("s_rst_clr", 32'(s_pool1_clr), 0);
      chk("s_rst_wen", 32'(s_f3_wen), 0);
      chk("s_rst_waddr", 32'(s_f3_waddr), 0);
    end else begin
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_ren", 32'(f2_ren), 0);
      chk("rst_raddr", 32'(f2_raddr), 0);
      chk("rst_clr", 32'(pool1_clr), 0);
      chk("rst_wen", 32'(f3_wen), 0);
      chk("rst_waddr", 32'(f3_waddr), 0);
    end
  endtask

  task automatic set_start(input bit sml, input logic v);
    if (sml) s_start = v;
    else start = v;
  endtask

  task automatic run_map(input bit sml, input int abort_at,
                         input bit hold, input bit pulse);
    int iw, ow, rl, n, k, w, r, c;
    bit e_clr, e_wen;
    iw = sml ? 4 : 28;
    ow = sml ? 2 : 14;
    rl = sml ? 2 : 1;
    n  = iw * iw;
    @(negedge clk);
    set_start(sml, 1'b1);
    for (int t = 0; t <= n + rl + 4; t++) begin
      @(negedge clk);
      cur_t = t;
      k = t % 4;
      w = t / 4;
      r = w / ow;
      c = w % ow;
      e_clr = (t >= rl) && (t - rl < n) && ((t - rl) % 4 == 0);
      e_wen = (t >= rl + 4) && ((t - rl - 4) % 4 == 0)
              && ((t - rl - 4) / 4 < ow * ow);
      chk("ren", 32'(sml ? s_f2_ren : f2_ren), 32'(t < n));
      if (t < n)
        chk("raddr", sml ? 32'(s_f2_raddr) : 32'(f2_raddr),
            32'((2 * r + k / 2) * iw + 2 * c + k % 2));
      chk("clr", 32'(sml ? s_pool1_clr : pool1_clr), 32'(e_clr));
      chk("wen", 32'(sml ? s_f3_wen : f3_wen), 32'(e_wen));
      if (e_wen)
        chk("waddr", sml ? 32'(s_f3_waddr) : 32'(f3_waddr),
            32'((t - rl - 4) / 4));
      chk("busy", 32'(sml ? s_busy : busy), 32'(t <= n + rl));
      chk("done", 32'(sml ? s_done : done), 32'(t == n + rl + 1));
      if (t == abort_at) begin
        set_start(sml, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        cur_t = t + 1;
        chk_zero(sml);
        rst = 1'b0;
        return;
      end
      if (t == 0 && !hold) set_start(sml, 1'b0);
      if (t == n + rl && pulse) set_start(sml, 1'b1);
      if (t == n + rl + 1) set_start(sml, 1'b0);
    end
  endtask

  initial begin
    logic signed [15:0] e;
    int b;
    rst = 1'b1;
    start = 1'b0;
    s_start = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero(1'b0);
    chk_zero(1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);

    for (int i = 0; i < 196; i++) f3mem[i] = 16'sh7fff;
    run_map(1'b0, -1, 1'b0, 1'b0);
    cur_t = 0;
    chk("win0", 32'(f3mem[0]), 32'(-19));
    for (int wi = 0; wi < 196; wi++) begin
      cur_t = wi;
      b = 2 * (wi / 14) * 28 + 2 * (wi % 14);
      e = smax(smax(pix(b), pix(b + 1)), smax(pix(b + 28), pix(b + 29)));
      chk("f3data", 32'(f3mem[wi]), 32'(e));
    end

    run_map(1'b0, -1, 1'b1, 1'b1);
    run_map(1'b0, -1, 1'b0, 1'b0);
    run_map(1'b0, 300, 1'b0, 1'b0);
    run_map(1'b0, -1, 1'b0, 1'b0);
    run_map(1'b1, -1, 1'b0, 1'b0);
    run_map(1'b1, -1, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
